// File: rtl/axi4s_pkg.sv
// rtl/axi4s_pkg.sv - shared stream ids and arbiter state type
//
// Purpose: constants and types shared by the stream arbiters of the UART
//          transmit path.
// Ports:   none (package).
package axi4s_pkg;

  // Packet tid values used by the memory-mapped bridge response stream.
  localparam logic [2:0] ID_B  = 3'd0;
  localparam logic [2:0] ID_AW = 3'd1;
  localparam logic [2:0] ID_AR = 3'd2;
  localparam logic [2:0] ID_R  = 3'd3;
  localparam logic [2:0] ID_W  = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: finds the first set request bit, searching upward from the slot
//          after last_i and wrapping around.
// Ports:
//   req_i   [N-1:0]      request vector, bit i belongs to requester i
//   last_i  [IDX_W-1:0]  index granted most recently
//   idx_o   [IDX_W-1:0]  chosen index (0 when nothing is requesting)
//   found_o              at least one request bit was set
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] cand;

  // k runs 1..N so that last_i itself is the final candidate examined:
  // the previous winner only gets the link again when nobody else asks.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/axi4s_packet_arbiter.sv
// rtl/axi4s_packet_arbiter.sv - packet-atomic round-robin stream merger
//
// Purpose: merges N_SRC packet streams onto one registered output stream;
//          a granted source keeps the output until its tlast beat is taken.
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tlast [N_SRC]  per-source handshake and last
//   s_tdata [N_SRC*DATA_W]  source i at [i*DATA_W +: DATA_W]
//   s_tid   [N_SRC*ID_W]    source i at [i*ID_W +: ID_W]
//   m_tvalid/m_tready/m_tlast/m_tdata/m_tid  merged output stream
//   grant_valid, grant_idx  lock status and index of the locked source
module axi4s_packet_arbiter #(
  parameter  int N_SRC  = 2,
  parameter  int DATA_W = 8,
  parameter  int ID_W   = 3,
  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [N_SRC-1:0]         s_tvalid,
  output logic [N_SRC-1:0]         s_tready,
  input  logic [N_SRC-1:0]         s_tlast,
  input  logic [N_SRC*DATA_W-1:0]  s_tdata,
  input  logic [N_SRC*ID_W-1:0]    s_tid,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [ID_W-1:0]          m_tid,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx
);

  import axi4s_pkg::arb_state_t;
  import axi4s_pkg::IDLE;
  import axi4s_pkg::LOCKED;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic [ID_W-1:0]     m_tid_q, m_tid_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic                out_free;
  logic                load;

  logic [DATA_W-1:0]   src_data [N_SRC];
  logic [ID_W-1:0]     src_id   [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign src_data[g] = s_tdata[g*DATA_W +: DATA_W];
    assign src_id[g]   = s_tid[g*ID_W +: ID_W];
  end

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (s_tvalid),
    .last_i  (last_grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // The output register can take a new beat when empty or draining now,
  // which gives full throughput inside a packet.
  assign out_free = !m_tvalid_q || m_tready;
  assign load     = (state_q == LOCKED) && s_tvalid[grant_idx_q] && out_free;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Leaving LOCKED does not wait for the tlast beat to
  // drain: the next source cannot load until the output register is free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found)              state_d = LOCKED;
      LOCKED:  if (load && s_tlast[grant_idx_q]) state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_tready    = '0;
    grant_valid = 1'b0;
    if (state_q == LOCKED) begin
      s_tready[grant_idx_q] = out_free;
      grant_valid           = 1'b1;
    end
  end

  // Grant bookkeeping and output register next state
  always_comb begin
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tid_d      = m_tid_q;
    if ((state_q == IDLE) && pick_found) begin
      grant_idx_d = pick_idx;
    end
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_tlast[grant_idx_q];
      m_tdata_d  = src_data[grant_idx_q];
      m_tid_d    = src_id[grant_idx_q];
      if (s_tlast[grant_idx_q]) begin
        last_grant_d = grant_idx_q;
      end
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(N_SRC - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tid_q      <= '0;
    end else begin
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tid_q      <= m_tid_d;
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tdata   = m_tdata_q;
  assign m_tid     = m_tid_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_axi4s_packet_arbiter.sv
// tb/tb_axi4s_packet_arbiter.sv - directed and randomized checks of the packet arbiter
module tb_axi4s_packet_arbiter;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int IW    = 3;
  localparam int XW    = 2;
  localparam int DEPTH = 64;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*IW-1:0] s_tid;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [IW-1:0]   m_tid;
  logic            grant_valid;
  logic [XW-1:0]   grant_idx;

  always #5 aclk = ~aclk;

  axi4s_packet_arbiter #(.N_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tdata     (s_tdata),
    .s_tid       (s_tid),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tdata     (m_tdata),
    .m_tid       (m_tid),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Source beats are {tid, data, last}.
  logic [11:0] sbuf [N][DEPTH];
  int          shead [N];
  int          stail [N];
  bit          drv_valid [N];
  bit          in_pkt [N];
  int          gap [N];
  int          gap_len [N];
  int          fired [N];
  bit          rnd_gap;
  bit          rnd_mrdy;
  logic [11:0] out_q [$];
  logic [11:0] exp_q [$];
  int          out_cyc [$];
  int          fire_log [$];
  int          model_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_drives();
    logic [11:0] b;
    for (int i = 0; i < N; i++) begin
      b = (shead[i] < stail[i]) ? sbuf[i][shead[i]] : 12'h000;
      s_tvalid[i]          = drv_valid[i];
      s_tlast[i]           = b[0];
      s_tdata[i*DW +: DW]  = b[8:1];
      s_tid[i*IW +: IW]    = b[11:9];
    end
  endtask

  // A source presents a packet's first beat at once; later beats may be
  // delayed by a gap, but a raised valid is held until it is accepted.
  task automatic update_valid();
    for (int i = 0; i < N; i++) begin
      if (!drv_valid[i] && (shead[i] < stail[i])) begin
        if (!in_pkt[i])      drv_valid[i] = 1'b1;
        else if (gap[i] > 0) gap[i]--;
        else                 drv_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic kick();
    update_valid();
    apply_drives();
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0; stail[i] = 0; drv_valid[i] = 1'b0; in_pkt[i] = 1'b0;
      gap[i] = 0; gap_len[i] = 0; fired[i] = 0;
    end
    out_q.delete(); exp_q.delete(); out_cyc.delete(); fire_log.delete();
    apply_drives();
  endtask

  task automatic tick();
    bit          sf [N];
    bit          mf;
    logic [11:0] mb;
    logic [11:0] b;
    #1;
    mf = m_tvalid && m_tready;
    mb = {m_tid, m_tdata, m_tlast};
    for (int i = 0; i < N; i++) begin
      sf[i] = s_tvalid[i] && s_tready[i];
      if (in_pkt[i]) chk("lock_held", 32'({grant_valid, grant_idx}), 32'({1'b1, XW'(i)}));
    end
    @(posedge aclk);
    cyc++;
    #1;
    if (mf) begin
      out_q.push_back(mb);
      out_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (sf[i]) begin
        b = sbuf[i][shead[i]];
        shead[i]++;
        fired[i]++;
        fire_log.push_back(i);
        drv_valid[i] = 1'b0;
        in_pkt[i]    = !b[0];
        if (b[0])         gap[i] = 0;
        else if (rnd_gap) gap[i] = (($urandom % 2) == 1) ? int'($urandom_range(1, 3)) : 0;
        else              gap[i] = gap_len[i];
      end
    end
    update_valid();
    if (rnd_mrdy) m_tready = (($urandom % 4) != 0);
    apply_drives();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_tb();
    @(posedge aclk);
    cyc++;
    #1;
    areset     = 1'b0;
    model_last = N - 1;
  endtask

  task automatic add_pkt(input int src, input int len, input bit rnd,
                         input logic [7:0] d0, input logic [2:0] tid);
    logic [7:0] d;
    logic [2:0] t;
    for (int k = 0; k < len; k++) begin
      d = rnd ? 8'($urandom) : d0 + 8'(k);
      t = rnd ? 3'($urandom) : tid;
      sbuf[src][stail[src]] = {t, d, (k == len - 1)};
      stail[src]++;
    end
  endtask

  // Reference: every source with a queued packet is requesting at each
  // arbitration, so whole packets leave in plain round-robin order.
  task automatic build_expected();
    int p [N];
    int pick;
    int c;
    bit done;
    for (int i = 0; i < N; i++) p[i] = shead[i];
    while (1) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        c = (model_last + k) % N;
        if (pick < 0 && p[c] < stail[c]) pick = c;
      end
      if (pick < 0) break;
      done = 1'b0;
      while (!done) begin
        exp_q.push_back(sbuf[pick][p[pick]]);
        done = sbuf[pick][p[pick]][0];
        p[pick]++;
      end
      model_last = pick;
    end
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (shead[i] < stail[i]) return 1'b0;
    return out_q.size() >= exp_q.size();
  endfunction

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !drained()) begin
      tick();
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, "_beats"}, 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk({tag, "_beat"}, 32'(out_q[k]), 32'(exp_q[k]));
  endtask

  initial begin
    logic [11:0] held;
    int          n;
    areset = 1'b1; m_tready = 1'b1; rnd_gap = 1'b0; rnd_mrdy = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tid = '0;
    model_last = N - 1;
    clear_tb();
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    end

    // One 3-beat packet from source 0
    add_pkt(0, 3, 1'b0, 8'hA1, axi4s_pkg::ID_R);
    build_expected();
    kick();
    tick();
    chk("t2_grant", 32'({grant_valid, grant_idx}), 32'({1'b1, 2'd0}));
    run_drain("t2", 50);
    check_stream("t2");
    for (int k = 1; k < out_cyc.size(); k++) chk("t2_consecutive", 32'(out_cyc[k] - out_cyc[k-1]), 32'd1);

    // Two sources, two 2-beat packets each: 0,1,0,1 with one idle cycle between
    do_reset();
    add_pkt(0, 2, 1'b0, 8'h10, 3'd1);
    add_pkt(0, 2, 1'b0, 8'h20, 3'd1);
    add_pkt(1, 2, 1'b0, 8'h30, 3'd2);
    add_pkt(1, 2, 1'b0, 8'h40, 3'd2);
    build_expected();
    kick();
    run_drain("t3", 80);
    check_stream("t3");
    n = (out_cyc.size() < exp_q.size()) ? out_cyc.size() : exp_q.size();
    for (int k = 1; k < n; k++)
      chk("t3_spacing", 32'(out_cyc[k] - out_cyc[k-1]), exp_q[k-1][0] ? 32'd2 : 32'd1);

    // Output stall mid-packet
    do_reset();
    add_pkt(0, 4, 1'b0, 8'h50, 3'd5);
    build_expected();
    kick();
    n = 0;
    while (n < 20 && out_q.size() < 1) begin tick(); n++; end
    chk("t4_first_beat", 32'(out_q.size()), 32'd1);
    m_tready = 1'b0;
    #1;
    held = {m_tid, m_tdata, m_tlast};
    chk("t4_stall_valid", 32'(m_tvalid), 32'd1);
    repeat (4) begin
      tick();
      chk("t4_stall_hold", 32'({m_tid, m_tdata, m_tlast}), 32'(held));
      chk("t4_stall_s_tready", 32'(s_tready), 32'd0);
    end
    m_tready = 1'b1;
    run_drain("t4", 50);
    check_stream("t4");

    // Locked source bubbles while source 1 requests
    do_reset();
    gap_len[0] = 3;
    add_pkt(0, 3, 1'b0, 8'h60, 3'd1);
    add_pkt(1, 2, 1'b0, 8'h70, 3'd2);
    build_expected();
    kick();
    run_drain("t5", 80);
    check_stream("t5");
    chk("t5_fires", 32'(fire_log.size()), 32'd5);
    for (int k = 0; k < fire_log.size() && k < 5; k++)
      chk("t5_fire_order", 32'(fire_log[k]), (k < 3) ? 32'd0 : 32'd1);
    if (out_cyc.size() >= 2) chk("t5_bubble_gap", 32'(out_cyc[1] - out_cyc[0]), 32'd4);
    else chk("t5_bubble_beats", 32'(out_cyc.size()), 32'd2);

    // Reset during beat 2 of a 4-beat packet
    do_reset();
    add_pkt(0, 4, 1'b0, 8'h80, 3'd3);
    build_expected();
    kick();
    n = 0;
    while (n < 20 && fired[0] < 2) begin tick(); n++; end
    chk("t6_two_beats", 32'(fired[0]), 32'd2);
    areset = 1'b1;
    @(posedge aclk);
    cyc++;
    #1;
    chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("t6_rst_s_tready", 32'(s_tready), 32'd0);
    clear_tb();
    model_last = N - 1;
    areset = 1'b0;
    add_pkt(1, 1, 1'b0, 8'h91, 3'd2);
    add_pkt(0, 1, 1'b0, 8'h90, 3'd1);
    build_expected();
    kick();
    tick();
    chk("t6_first_grant", 32'({grant_valid, grant_idx}), 32'({1'b1, 2'd0}));
    run_drain("t6", 40);
    check_stream("t6");

    // Randomized traffic, bubbles and back-pressure; arbitration history carries over
    rnd_gap  = 1'b1;
    rnd_mrdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        shead[i] = 0; stail[i] = 0;
      end
      out_q.delete(); exp_q.delete(); out_cyc.delete(); fire_log.delete();
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(0, 3));
        for (int p = 0; p < n; p++) add_pkt(i, int'($urandom_range(1, 4)), 1'b1, 8'h00, 3'd0);
      end
      build_expected();
      kick();
      run_drain("rnd", 800);
      check_stream("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
